// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRBS generator and checker.
// Both ends use TAPS_DEFAULT so that they follow the same sequence.
package lfsr_pkg;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] TAPS_DEFAULT = 16'hB400;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;
endpackage

// File: rtl/lfsr_checker_if.sv
// Serial PRBS input and checker status bundle.
// Defining LFSR_CHECKER_STATS_EN adds the bit_count and lock_loss statistics.
interface lfsr_checker_if;
  import lfsr_pkg::*;

  logic              bit_in;
  logic              bit_valid;
  logic              locked;
  logic              bit_err;
  logic [15:0]       err_count;
  logic              zero_det;
  logic [LFSR_W-1:0] pred_state;
`ifdef LFSR_CHECKER_STATS_EN
  logic [31:0]       bit_count;
  logic [7:0]        lock_loss;

  modport master (
    output bit_in, bit_valid,
    input  locked, bit_err, err_count, zero_det, pred_state, bit_count, lock_loss
  );
  modport slave (
    input  bit_in, bit_valid,
    output locked, bit_err, err_count, zero_det, pred_state, bit_count, lock_loss
  );
`else
  modport master (
    output bit_in, bit_valid,
    input  locked, bit_err, err_count, zero_det, pred_state
  );
  modport slave (
    input  bit_in, bit_valid,
    output locked, bit_err, err_count, zero_det, pred_state
  );
`endif
endinterface

// File: rtl/lfsr_next.sv
// Combinational LFSR next-bit function.
// The generator and the checker share this module.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS = TAPS_DEFAULT
) (
  input  logic [LFSR_W-1:0] sh,
  output logic              p
);
  assign p = ^(sh & TAPS);
endmodule

// File: rtl/lfsr_checker.sv
// PRBS receive checker: loads 16 received bits, verifies the prediction, then free-runs while locked.
// Defining LFSR_CHECKER_STATS_EN adds the bit_count and lock_loss counters.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS     = TAPS_DEFAULT,
  parameter int                LOCK_CNT = 8,
  parameter int                LOSS_CNT = 4
) (
  input logic          clk,
  input logic          reset,
  lfsr_checker_if.slave link
);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state, state_n;
  logic [LFSR_W-1:0] sh, sh_n;
  logic [3:0]        cnt, cnt_n;
  logic [7:0]        match_cnt, match_n;
  logic [3:0]        miss_cnt, miss_n;
  logic              locked_q, locked_n;
  logic              bit_err_q, bit_err_n;
  logic [15:0]       err_cnt_q, err_cnt_n;
  logic              zero_det_q, zero_det_n;
  logic              loss_evt;
  logic              p;

  lfsr_next #(.TAPS(TAPS)) u_next (
    .sh (sh),
    .p  (p)
  );

  always_comb begin
    state_n    = state;
    sh_n       = sh;
    cnt_n      = cnt;
    match_n    = match_cnt;
    miss_n     = miss_cnt;
    locked_n   = locked_q;
    bit_err_n  = 1'b0;
    err_cnt_n  = err_cnt_q;
    zero_det_n = zero_det_q;
    loss_evt   = 1'b0;
    if (link.bit_valid) begin
      case (state)
        HUNT: begin
          sh_n = {sh[LFSR_W-2:0], link.bit_in};
          if (cnt == 4'd15) begin
            cnt_n = 4'd0;
            // An all-zero load can never predict a live stream, so keep hunting.
            if (sh_n != '0) begin
              state_n    = VERIFY;
              zero_det_n = 1'b0;
              match_n    = 8'd0;
            end else begin
              zero_det_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        VERIFY: begin
          sh_n = {sh[LFSR_W-2:0], link.bit_in};
          if (link.bit_in == p) begin
            if (match_cnt == LOCK_LAST) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
              match_n  = 8'd0;
              miss_n   = 4'd0;
            end else begin
              match_n = match_cnt + 8'd1;
            end
          end else begin
            state_n = HUNT;
            cnt_n   = 4'd0;
            match_n = 8'd0;
          end
        end
        LOCKED: begin
          // Shift in the prediction so a single channel error is counted only once.
          sh_n = {sh[LFSR_W-2:0], p};
          if (link.bit_in != p) begin
            bit_err_n = 1'b1;
            err_cnt_n = sat_inc16(err_cnt_q);
            if (miss_cnt == LOSS_LAST) begin
              state_n  = HUNT;
              locked_n = 1'b0;
              cnt_n    = 4'd0;
              miss_n   = 4'd0;
              loss_evt = 1'b1;
            end else begin
              miss_n = miss_cnt + 4'd1;
            end
          end else begin
            miss_n = 4'd0;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      sh         <= '0;
      cnt        <= 4'd0;
      match_cnt  <= 8'd0;
      miss_cnt   <= 4'd0;
      locked_q   <= 1'b0;
      bit_err_q  <= 1'b0;
      err_cnt_q  <= 16'd0;
      zero_det_q <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      cnt        <= cnt_n;
      match_cnt  <= match_n;
      miss_cnt   <= miss_n;
      locked_q   <= locked_n;
      bit_err_q  <= bit_err_n;
      err_cnt_q  <= err_cnt_n;
      zero_det_q <= zero_det_n;
    end
  end

  assign link.locked     = locked_q;
  assign link.bit_err    = bit_err_q;
  assign link.err_count  = err_cnt_q;
  assign link.zero_det   = zero_det_q;
  assign link.pred_state = sh;

`ifdef LFSR_CHECKER_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [31:0] bit_cnt_q;
  logic [7:0]  lock_loss_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q   <= 32'd0;
      lock_loss_q <= 8'd0;
    end else begin
      if (link.bit_valid && state == LOCKED) bit_cnt_q <= sat_inc32(bit_cnt_q);
      if (loss_evt) lock_loss_q <= sat_inc8(lock_loss_q);
    end
  end

  assign link.bit_count = bit_cnt_q;
  assign link.lock_loss = lock_loss_q;
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a reference generator drives the stream and each cycle queues the expected status.
// A separate monitor pops the queue and compares one entry per clock.
module tb_lfsr_checker;
  import lfsr_pkg::*;

  typedef struct {
    logic        el;
    logic        ee;
    logic [15:0] ec;
    logic        ezd;
    logic [15:0] eps;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  lfsr_checker_if link();

  lfsr_checker dut (
    .clk   (clk),
    .reset (reset),
    .link  (link)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] r;
  int          k;
  logic [15:0] dev;

  // Expected checker register: the last k received bits, with dev marking injected flips.
  function automatic logic [15:0] exp_ps();
    logic [16:0] m;
    m = (17'h1 << k) - 17'h1;
    if (k >= 16) return r ^ dev;
    return (r & m[15:0]) ^ dev;
  endfunction

  task automatic gen(output logic b);
    b = ^(r & TAPS_DEFAULT);
    r = {r[14:0], b};
  endtask

  task automatic step(input logic rs, input logic v, input logic b, input logic fl,
                      input logic el, input logic ee, input logic [15:0] ec, input logic ezd);
    exp_t e;
    @(negedge clk);
    reset          = rs;
    link.bit_valid = v;
    link.bit_in    = b;
    if (rs) begin
      k   = 0;
      dev = '0;
    end else if (v) begin
      if (k < 16) k++;
      dev = {dev[14:0], fl};
    end
    e.el  = el;
    e.ee  = ee;
    e.ec  = ec;
    e.ezd = ezd;
    e.eps = exp_ps();
    sb.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, req);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp("locked",     32'(link.locked),     32'(e.el));
      cmp("bit_err",    32'(link.bit_err),    32'(e.ee));
      cmp("err_count",  32'(link.err_count),  32'(e.ec));
      cmp("zero_det",   32'(link.zero_det),   32'(e.ezd));
      cmp("pred_state", 32'(link.pred_state), 32'(e.eps));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic b;
    int nv;
    link.bit_valid = 1'b0;
    link.bit_in    = 1'b0;
    r   = 16'h000D;
    k   = 0;
    dev = '0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 16'd0, 0);
    step(1, 0, 0, 0, 0, 0, 16'd0, 0);

    // Clean lock and 1000 error-free bits
    for (int n = 1; n <= 1000; n++) begin
      gen(b);
      step(0, 1, b, 0, n >= 24, 0, 16'd0, 0);
    end

    // Single inverted bit while locked
    gen(b);
    step(0, 1, ~b, 0, 1, 1, 16'd1, 0);
    for (int n = 1; n <= 50; n++) begin
      gen(b);
      step(0, 1, b, 0, 1, 0, 16'd1, 0);
    end

    // Four consecutive inverted bits drop lock, then relock with count retained
    for (int i = 1; i <= 4; i++) begin
      gen(b);
      step(0, 1, ~b, 0, i < 4, 1, 16'(1 + i), 0);
    end
    for (int n = 1; n <= 30; n++) begin
      gen(b);
      step(0, 1, b, 0, n >= 24, 0, 16'd5, 0);
    end

    // Reset with valid high, build err_count=3, then reset mid-lock
    step(1, 1, 1, 0, 0, 0, 16'd0, 0);
    for (int n = 1; n <= 24; n++) begin
      gen(b);
      step(0, 1, b, 0, n >= 24, 0, 16'd0, 0);
    end
    for (int e = 1; e <= 3; e++) begin
      gen(b);
      step(0, 1, ~b, 0, 1, 1, 16'(e), 0);
      for (int n = 1; n <= 5; n++) begin
        gen(b);
        step(0, 1, b, 0, 1, 0, 16'(e), 0);
      end
    end
    gen(b);
    step(1, 1, ~b, 0, 0, 0, 16'd0, 0);
    for (int n = 1; n <= 30; n++) begin
      gen(b);
      step(0, 1, b, 0, n >= 24, 0, 16'd0, 0);
    end

    // Gapped valid: invalid cycles carry garbage and must change nothing
    step(1, 0, 0, 0, 0, 0, 16'd0, 0);
    nv = 0;
    for (int n = 1; n <= 60; n++) begin
      gen(b);
      nv++;
      step(0, 1, b, 0, nv >= 24, 0, 16'd0, 0);
      step(0, 0, ~b, 0, nv >= 24, 0, 16'd0, 0);
    end

    // All-zero stream, then a live stream clears zero_det
    step(1, 0, 0, 0, 0, 0, 16'd0, 0);
    r = 16'h0000;
    for (int n = 1; n <= 48; n++) begin
      gen(b);
      step(0, 1, b, 0, 0, 0, 16'd0, n >= 16);
    end
    r = 16'h000D;
    k = 0;
    for (int n = 1; n <= 30; n++) begin
      gen(b);
      step(0, 1, b, 0, n >= 24, 0, 16'd0, n < 16);
    end

    // Mismatch during VERIFY: back to HUNT silently
    step(1, 0, 0, 0, 0, 0, 16'd0, 0);
    for (int n = 1; n <= 16; n++) begin
      gen(b);
      step(0, 1, b, 0, 0, 0, 16'd0, 0);
    end
    gen(b);
    step(0, 1, ~b, 1, 0, 0, 16'd0, 0);
    for (int n = 1; n <= 30; n++) begin
      gen(b);
      step(0, 1, b, 0, n >= 24, 0, 16'd0, 0);
    end

    @(negedge clk);
    link.bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain cycle=%0d got=%0d expected=0", cyc, sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
